// File: rtl/t0_pkg.sv
// Shared types and constants for the t0 command fetch path: opcodes, header
// bytes, payload lengths, the dispatched command record and fetch FSM states.
package t0_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_MOVE  = 2'd1,
      OP_DWELL = 2'd2
   } opcode_t;

   localparam logic [7:0] HDR_NOP   = 8'h00;
   localparam logic [7:0] HDR_MOVE  = 8'h01;
   localparam logic [7:0] HDR_DWELL = 8'h02;

   localparam logic [3:0] LEN_NOP   = 4'd0;
   localparam logic [3:0] LEN_MOVE  = 4'd8;
   localparam logic [3:0] LEN_DWELL = 4'd2;

   typedef struct packed {
      opcode_t          op;
      logic [0:2][15:0] delta;
      logic [15:0]      period;
   } cmd_t;

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      PAY  = 2'd1,
      DISP = 2'd2
   } fetch_state_t;

   function automatic logic [3:0] payload_len(input opcode_t op);
      case (op)
         OP_MOVE:  return LEN_MOVE;
         OP_DWELL: return LEN_DWELL;
         default:  return LEN_NOP;
      endcase
   endfunction

endpackage

// File: rtl/t0_byte_fetch.sv
// FIFO byte handshake: synchronises data_ready, detects its rising edge and
// generates data_request plus a one-cycle byte-accept strobe.
module t0_byte_fetch (
   input  logic clk,
   input  logic N_reset,
   input  logic data_ready,
   input  logic want,
   output logic data_request,
   output logic accept
);

   logic ready_s1;
   logic ready_s2;
   logic ready_d;
   logic rise;

   // Only a fresh low->high edge counts, so a level left high from an earlier
   // byte can never be consumed twice.
   assign rise   = ready_s2 & ~ready_d;
   assign accept = rise & data_request;

   always_ff @(posedge clk or negedge N_reset) begin
      if (!N_reset) begin
         ready_s1     <= 1'b0;
         ready_s2     <= 1'b0;
         ready_d      <= 1'b0;
         data_request <= 1'b0;
      end else begin
         ready_s1     <= data_ready;
         ready_s2     <= ready_s1;
         ready_d      <= ready_s2;
         data_request <= want & ~accept;
      end
   end

endmodule

// File: rtl/t0_cmd_fetch.sv
// Command fetch controller: parses header/payload bytes from the FIFO into
// NOP/MOVE/DWELL commands and hands them to the motion engine (valid/ready).
module t0_cmd_fetch
   import t0_pkg::*;
#(
   parameter int AXES           = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               N_reset,
   input  logic               data_ready,
   input  logic [7:0]         data,
   output logic               data_request,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic [1:0]         cmd_op,
   output logic signed [15:0] cmd_delta [0:AXES-1],
   output logic [15:0]        cmd_period,
   output logic               cmd_error,
   output fetch_state_t       fsm_state
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   fetch_state_t  state;
   opcode_t       op_q;
   cmd_t          cmd_q;
   logic [3:0]    cnt;
   logic [TW-1:0] tcnt;
   logic [55:0]   pay_q;
   logic [63:0]   pay_next;
   logic          want;
   logic          accept;
   logic          timeout_hit;

   t0_byte_fetch u_byte_fetch (
      .clk          (clk),
      .N_reset      (N_reset),
      .data_ready   (data_ready),
      .want         (want),
      .data_request (data_request),
      .accept       (accept)
   );

   // Little-endian shift-in: after the last byte the period always sits in
   // the top 16 bits, for both MOVE (8 bytes) and DWELL (2 bytes).
   assign pay_next = {data, pay_q};

   // tcnt counts stalled cycles since the last accept; hitting the limit here
   // makes the registered abort land on the TIMEOUT_CYCLES-th stalled cycle.
   assign timeout_hit = (state == PAY) && !accept && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      want = 1'b0;
      case (state)
         HDR:     want = 1'b1;
         PAY:     want = ~timeout_hit;
         DISP:    want = cmd_ready;
         default: want = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge N_reset) begin
      if (!N_reset) begin
         state     <= HDR;
         op_q      <= OP_NOP;
         cmd_q     <= '0;
         cmd_valid <= 1'b0;
         cmd_error <= 1'b0;
         cnt       <= '0;
         tcnt      <= '0;
         pay_q     <= '0;
      end else begin
         cmd_error <= 1'b0;
         case (state)
            HDR: begin
               if (accept) begin
                  case (data)
                     HDR_NOP: begin
                        cmd_q     <= '0;
                        cmd_valid <= 1'b1;
                        state     <= DISP;
                     end
                     HDR_MOVE, HDR_DWELL: begin
                        op_q  <= opcode_t'(data[1:0]);
                        cnt   <= '0;
                        tcnt  <= TW'(1);
                        pay_q <= '0;
                        state <= PAY;
                     end
                     default: cmd_error <= 1'b1;
                  endcase
               end
            end
            PAY: begin
               if (accept) begin
                  pay_q <= pay_next[63:8];
                  cnt   <= cnt + 4'd1;
                  tcnt  <= TW'(1);
                  if (cnt == payload_len(op_q) - 4'd1) begin
                     cmd_q.op     <= op_q;
                     cmd_q.period <= pay_next[63:48];
                     if (op_q == OP_MOVE) begin
                        cmd_q.delta[0] <= pay_next[15:0];
                        cmd_q.delta[1] <= pay_next[31:16];
                        cmd_q.delta[2] <= pay_next[47:32];
                     end else begin
                        cmd_q.delta <= '0;
                     end
                     cmd_valid <= 1'b1;
                     state     <= DISP;
                  end
               end else if (timeout_hit) begin
                  cmd_error <= 1'b1;
                  state     <= HDR;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            DISP: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= HDR;
               end
            end
            default: state <= HDR;
         endcase
      end
   end

   assign cmd_op     = cmd_q.op;
   assign cmd_period = cmd_q.period;
   assign fsm_state  = state;

   for (genvar a = 0; a < AXES; a++) begin : g_delta
      assign cmd_delta[a] = cmd_q.delta[a];
   end

endmodule

// File: tb/tb_t0_cmd_fetch.sv
// Self-checking bench for t0_cmd_fetch: drives the FIFO byte handshake and
// scores dispatched commands against an expected queue.
module tb_t0_cmd_fetch;
   import t0_pkg::*;

   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               N_reset = 1'b0;
   logic               data_ready = 1'b0;
   logic [7:0]         data = 8'h00;
   logic               data_request;
   logic               cmd_valid;
   logic               cmd_ready = 1'b0;
   logic [1:0]         cmd_op;
   logic signed [15:0] cmd_delta [0:2];
   logic [15:0]        cmd_period;
   logic               cmd_error;
   fetch_state_t       fsm_state;

   int n_checks = 0;
   int n_errors = 0;
   int err_seen = 0;
   int err_exp  = 0;
   int bad;
   int n;
   logic [65:0] exp_q[$];

   t0_cmd_fetch #(.AXES(3), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk          (clk),
      .N_reset      (N_reset),
      .data_ready   (data_ready),
      .data         (data),
      .data_request (data_request),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_delta    (cmd_delta),
      .cmd_period   (cmd_period),
      .cmd_error    (cmd_error),
      .fsm_state    (fsm_state)
   );

   always #20 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [65:0] pk(input logic [1:0] op, input logic [15:0] d0,
                                       input logic [15:0] d1, input logic [15:0] d2,
                                       input logic [15:0] p);
      return {op, d0, d1, d2, p};
   endfunction

   always @(negedge clk) begin
      if (N_reset && cmd_error) err_seen++;
      if (N_reset && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0)
            check("unexpected_cmd", 66'(exp_q.size()), 66'd1);
         else
            check("cmd", {cmd_op, cmd_delta[0], cmd_delta[1], cmd_delta[2], cmd_period},
                  exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic lvl, input string tag);
      for (int i = 0; i < 300 && data_request !== lvl; i++) tick();
      check(tag, 66'(data_request), 66'(lvl));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last);
      tick();
      tick();
      wait_req(1'b1, "req_high");
      data       = b;
      data_ready = 1'b1;
      wait_req(1'b0, "req_drop");
      data_ready = 1'b0;
      if (last) check("valid_latency", 66'(cmd_valid), 66'd1);
   endtask

   task automatic send_move(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] p);
      exp_q.push_back(pk(2'd1, d0, d1, d2, p));
      send_byte(8'h01, 1'b0);
      send_byte(d0[7:0], 1'b0); send_byte(d0[15:8], 1'b0);
      send_byte(d1[7:0], 1'b0); send_byte(d1[15:8], 1'b0);
      send_byte(d2[7:0], 1'b0); send_byte(d2[15:8], 1'b0);
      send_byte(p[7:0], 1'b0);  send_byte(p[15:8], 1'b1);
   endtask

   task automatic send_dwell(input logic [15:0] p);
      exp_q.push_back(pk(2'd2, 16'd0, 16'd0, 16'd0, p));
      send_byte(8'h02, 1'b0);
      send_byte(p[7:0], 1'b0);
      send_byte(p[15:8], 1'b1);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_req", 66'(data_request), 66'd0);
      check("rst_valid", 66'(cmd_valid), 66'd0);
      check("rst_cmd", {cmd_op, cmd_delta[0], cmd_delta[1], cmd_delta[2], cmd_period}, 66'd0);
      check("rst_err", 66'(cmd_error), 66'd0);
      check("rst_state", 66'(fsm_state), 66'(HDR));
      N_reset = 1'b1;
      tick();

      // Reset in the middle of a MOVE payload discards it.
      send_byte(8'h01, 1'b0);
      send_byte(8'h0A, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'hF6, 1'b0);
      tick();
      tick();
      check("pre_rst_req", 66'(data_request), 66'd1);
      N_reset = 1'b0;
      #1;
      check("mid_rst_req", 66'(data_request), 66'd0);
      check("mid_rst_state", 66'(fsm_state), 66'(HDR));
      check("mid_rst_valid", 66'(cmd_valid), 66'd0);
      tick();
      tick();
      N_reset = 1'b1;
      tick();
      exp_q.push_back(pk(2'd0, 16'd0, 16'd0, 16'd0, 16'd0));
      send_byte(8'h00, 1'b1);
      check("nop_op", 66'(cmd_op), 66'd0);
      check("nop_period", 66'(cmd_period), 66'd0);
      cmd_ready = 1'b1;
      tick();

      // MOVE with the engine already ready: a single-cycle valid pulse.
      send_move(16'd10, 16'hFFF6, 16'd0, 16'd1000);
      tick();
      check("move_valid_pulse", 66'(cmd_valid), 66'd0);
      check("move_req_back", 66'(data_request), 66'd1);

      // DWELL held in dispatch; a byte edge arrives there and must be ignored.
      cmd_ready = 1'b0;
      send_dwell(16'd64);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!(cmd_valid === 1'b1 && cmd_op === 2'd2 && cmd_period === 16'd64 &&
               data_request === 1'b0)) bad++;
         if (i == 5) begin
            data       = 8'h00;
            data_ready = 1'b1;
         end
         tick();
      end
      check("dwell_stable", 66'(bad), 66'd0);
      cmd_ready = 1'b1;
      tick();
      check("dwell_req_after_hs", 66'(data_request), 66'd1);
      check("dwell_valid_drop", 66'(cmd_valid), 66'd0);

      // data_ready still high across the request rise: no accept until toggled.
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (data_request !== 1'b1 || fsm_state !== HDR) bad++;
         tick();
      end
      check("stale_level_no_accept", 66'(bad), 66'd0);
      data_ready = 1'b0;
      tick();
      tick();
      exp_q.push_back(pk(2'd0, 16'd0, 16'd0, 16'd0, 16'd0));
      data_ready = 1'b1;
      wait_req(1'b0, "toggle_accept");
      check("toggle_valid", 66'(cmd_valid), 66'd1);
      tick();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (data_request !== 1'b1) bad++;
         tick();
      end
      check("one_byte_per_toggle", 66'(bad), 66'd0);
      data_ready = 1'b0;

      // Bad header: one error pulse, no command, then a NOP parses normally.
      err_exp++;
      send_byte(8'h07, 1'b0);
      check("bad_hdr_err_pulse", 66'(cmd_error), 66'd1);
      tick();
      check("bad_hdr_err_clear", 66'(cmd_error), 66'd0);
      exp_q.push_back(pk(2'd0, 16'd0, 16'd0, 16'd0, 16'd0));
      send_byte(8'h00, 1'b1);
      err_exp++;
      send_byte(8'hFF, 1'b0);
      check("hdr_ff_err_pulse", 66'(cmd_error), 66'd1);

      // Payload stall: abort on the TIMEOUT-th stalled cycle, then resync.
      err_exp++;
      send_byte(8'h01, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      n = 0;
      while (cmd_error !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("timeout_cycles", 66'(n), 66'(TIMEOUT - 1));
      check("timeout_req_low", 66'(data_request), 66'd0);
      check("timeout_state", 66'(fsm_state), 66'(HDR));
      send_dwell(16'h1234);

      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 1) == 1)
            send_move(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
         else
            send_dwell(16'($urandom_range(0, 65535)));
      end

      repeat (4) tick();
      check("err_count", 66'(err_seen), 66'(err_exp));
      check("queue_empty", 66'(exp_q.size()), 66'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
